mdl_satacmd_queue: RTL
======================

Name: mdl_satacmd_queue

Overview:
- Single-clock bench model of a SATA device's command layer.
- Parses Host-to-Device Register FISes arriving on the TX stream and decodes the command byte against the supported-command set.
- Queues each accepted command. After a programmable delay it returns one Device-to-Host Register FIS per command: status/error reflect command validity or error injection, and LBA/count are echoed back.
- Sits between the link-layer TX stream and the RX stream in the SATA testbench.

Parameters:
- LGDEPTH, 2, log2 of the pending-command queue depth (depth = 2^LGDEPTH).
- RESP_DELAY, 4, idle cycles between a queued command becoming head-of-queue and the first response word (0 = none).
- OK_STATUS, 8'h50, status byte for a known command (DRDY|DSC).
- ERR_STATUS, 8'h51, status byte for an unknown or injected-error command.
- ERR_CODE, 8'h04, error byte on failure (ABRT).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- s_valid  in  1  TX word valid; no backpressure, a word is taken every valid cycle
- s_data  in  32  TX FIS word
- s_last  in  1  final word of frame
- s_abort  in  1  discard frame in progress
- s_full  out  1  queue full
- s_empty  out  1  queue empty and output idle
- i_inject_err  in  1  sampled at frame end; forces an error response for that command
- m_valid  out  1  response word valid
- m_ready  in  1  sink accepts word
- m_data  out  32  response word
- m_last  out  1  final response word
- o_drop_count  out  16  frames dropped (malformed or queue full), saturating

Behaviour:
- Reset: queue empty, word counter 0, state IDLE, m_valid=0, m_last=0, m_data=0, o_drop_count=0, s_full=0, s_empty=1.
- Input parser:
  - 3-bit word index, incremented on each s_valid.
  - Word0 is checked: [7:0]==8'h27 and C bit [15]==1; command byte is [23:16].
  - Word1 supplies device [31:24] and LBA[23:0]. Word2 supplies LBA[47:24]. Word3 supplies count [15:0]. Word4 is ignored.
- Frame acceptance:
  - A frame is accepted when s_last arrives on word index 4, word0 passed its check, s_abort is low, and the queue is not full.
  - On acceptance the model pushes {known, cmd, device, LBA48, count}.
  - known = cmd is in the supported set and i_inject_err is low.
  - Supported set: 00,0B,40,42,44,45,51,63,77,78,B0,B2,B4,E0–E3,E5–E7,EA,EF,F5,20,24,2B,2F,5C,EC,30,34,3B,3F,5E,E8,F1,F2,F4,F6,25,2A,C8,E9,06,07,35,3A,3D,57,CA,EB.
- Drops:
  - s_last on any other index, a bad word0, or the queue full at s_last: frame dropped, o_drop_count+1 (saturates at FFFF), index returns to 0.
  - Words past index 4 without s_last are ignored; the frame drops when s_last arrives.
- s_abort: any cycle with s_abort=1 clears the index and discards the frame. It is not counted as a drop. It takes priority over s_last in the same cycle.
- Response FSM:
  - IDLE→WAIT when the queue is non-empty (IDLE→SEND if RESP_DELAY=0).
  - WAIT counts RESP_DELAY cycles, then goes to SEND.
  - SEND drives 5 words with index advancing on m_valid&&m_ready:
    - W0={err, status, 8'h40 (I bit), 8'h34}
    - W1={device, LBA[23:0]}
    - W2={8'h00, LBA[47:24]}
    - W3={16'h0, count}
    - W4=0
  - Known command: status=OK_STATUS, err=8'h00. Otherwise status=ERR_STATUS, err=ERR_CODE.
  - m_last=1 only with W4.
  - On W4 handshake: pop the queue, m_valid drops next cycle, state returns to IDLE. Minimum one idle cycle between responses.
- Output stability: m_data and m_valid hold steady while m_valid&&!m_ready. m_data=0 whenever m_valid=0.
- Queue push and pop in the same cycle are both honoured; occupancy is unchanged.
- s_full = occupancy==2^LGDEPTH. s_empty = occupancy==0 && state==IDLE.
- Reset mid-frame or mid-response returns all state to reset values. No partial response is emitted afterward.

Test Plan:
- Identify device: frame words 0x00EC8027, 0xE0000000, 0, 0x00000001, 0, m_ready=1 → after 4 WAIT cycles: 0x00504034, 0xE0000000, 0, 0x00000001, 0 (m_last on word 5).
- Unknown cmd 0x99 → W0=0x04514034. Same result for cmd 0xEC with i_inject_err=1 at s_last.
- s_abort on word 2 of a READ DMA EXT (0x25), followed by a clean 0x25 frame with LBA 0x123456789ABC → exactly one response, W1[23:0]=0x789ABC, W2=0x00123456. o_drop_count stays 0.
- Malformed frames (s_last on word 3; word0=0x00EC0027 with C clear) → no response, o_drop_count=2.
- LGDEPTH=1, m_ready=0, three back-to-back valid frames → s_full after the second, third frame dropped (o_drop_count=1). Releasing m_ready yields exactly 2 responses in order.
- m_ready toggling 1-0-1 each cycle during SEND → each word is held until accepted, order preserved, s_empty=1 only after the final W4 handshake.

Source files
------------

// File: rtl/mdl_satacmd_queue.sv
// Bench model of a SATA device command layer: parses H2D Register FISes, queues
// accepted commands and returns one D2H Register FIS per command after a delay.
module mdl_satacmd_queue #(
    parameter int unsigned LGDEPTH    = 2,
    parameter int unsigned RESP_DELAY = 4,
    parameter logic [7:0]  OK_STATUS  = 8'h50,
    parameter logic [7:0]  ERR_STATUS = 8'h51,
    parameter logic [7:0]  ERR_CODE   = 8'h04
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        s_abort,
    output logic        s_full,
    output logic        s_empty,
    input  logic        i_inject_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic [15:0] o_drop_count
);
    localparam int unsigned Depth = 1 << LGDEPTH;
    localparam int unsigned DlyW  = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam int unsigned EntW  = 1 + 8 + 8 + 48 + 16;

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

    function automatic logic cmd_supported(input logic [7:0] c);
        case (c)
            8'h00, 8'h0B, 8'h40, 8'h42, 8'h44, 8'h45, 8'h51, 8'h63, 8'h77, 8'h78,
            8'hB0, 8'hB2, 8'hB4, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE5, 8'hE6, 8'hE7,
            8'hEA, 8'hEF, 8'hF5, 8'h20, 8'h24, 8'h2B, 8'h2F, 8'h5C, 8'hEC, 8'h30,
            8'h34, 8'h3B, 8'h3F, 8'h5E, 8'hE8, 8'hF1, 8'hF2, 8'hF4, 8'hF6, 8'h25,
            8'h2A, 8'hC8, 8'hE9, 8'h06, 8'h07, 8'h35, 8'h3A, 8'h3D, 8'h57, 8'hCA,
            8'hEB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [2:0]   idx_q, idx_d;
    logic         w0ok_q, w0ok_d;
    logic [7:0]   cmd_q, cmd_d, dev_q, dev_d;
    logic [47:0]  lba_q, lba_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  drop_q, drop_d;
    logic [LGDEPTH:0] wr_q, wr_d, rd_q, rd_d, occ;
    logic [EntW-1:0]  mem_q [Depth];
    state_e       state_q, state_d;
    logic [DlyW-1:0] dly_q, dly_d;
    logic [2:0]   oidx_q, oidx_d;
    logic         push, pop, drop;

    assign occ     = wr_q - rd_q;
    assign s_full  = (occ == (LGDEPTH + 1)'(Depth));
    assign s_empty = (occ == '0) && (state_q == StIdle);
    assign o_drop_count = drop_q;

    // Input parser: fields are captured by word index; acceptance is decided on s_last.
    always_comb begin
        idx_d  = idx_q;
        w0ok_d = w0ok_q;
        cmd_d  = cmd_q;
        dev_d  = dev_q;
        lba_d  = lba_q;
        cnt_d  = cnt_q;
        push   = 1'b0;
        drop   = 1'b0;
        if (s_abort) begin
            idx_d = '0;
        end else if (s_valid) begin
            case (idx_q)
                3'd0: begin
                    w0ok_d = (s_data[7:0] == 8'h27) && s_data[15];
                    cmd_d  = s_data[23:16];
                end
                3'd1: begin
                    dev_d        = s_data[31:24];
                    lba_d[23:0]  = s_data[23:0];
                end
                3'd2: lba_d[47:24] = s_data[23:0];
                3'd3: cnt_d = s_data[15:0];
                default: ;
            endcase
            if (s_last) begin
                idx_d = '0;
                if (idx_q == 3'd4 && w0ok_q && !s_full) push = 1'b1;
                else                                     drop = 1'b1;
            end else if (idx_q < 3'd5) begin
                // Saturate past the last meaningful word so a long frame never wraps to 4.
                idx_d = idx_q + 3'd1;
            end
        end
        drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        wr_d   = wr_q + (LGDEPTH + 1)'(push);
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        oidx_d  = oidx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                oidx_d = '0;
                dly_d  = '0;
                if (occ != '0) state_d = (RESP_DELAY == 0) ? StSend : StWait;
            end
            StWait: begin
                if (dly_q == DlyW'(RESP_DELAY - 1)) state_d = StSend;
                else                                 dly_d   = dly_q + 1'b1;
            end
            StSend: begin
                if (m_ready) begin
                    if (oidx_q == 3'd4) begin
                        pop     = 1'b1;
                        oidx_d  = '0;
                        state_d = StIdle;
                    end else begin
                        oidx_d = oidx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        rd_d = rd_q + (LGDEPTH + 1)'(pop);
    end

    logic        hd_known;
    logic [7:0]  hd_dev;
    logic [47:0] hd_lba;
    logic [15:0] hd_cnt;
    assign hd_known = mem_q[rd_q[LGDEPTH-1:0]][EntW-1];
    assign hd_dev   = mem_q[rd_q[LGDEPTH-1:0]][71:64];
    assign hd_lba   = mem_q[rd_q[LGDEPTH-1:0]][63:16];
    assign hd_cnt   = mem_q[rd_q[LGDEPTH-1:0]][15:0];

    always_comb begin
        m_valid = (state_q == StSend);
        m_last  = 1'b0;
        m_data  = '0;
        if (m_valid) begin
            unique case (oidx_q)
                3'd0: m_data = hd_known ? {8'h00, OK_STATUS, 8'h40, 8'h34}
                                        : {ERR_CODE, ERR_STATUS, 8'h40, 8'h34};
                3'd1: m_data = {hd_dev, hd_lba[23:0]};
                3'd2: m_data = {8'h00, hd_lba[47:24]};
                3'd3: m_data = {16'h0000, hd_cnt};
                default: begin
                    m_data = '0;
                    m_last = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_q[LGDEPTH-1:0]] <= {cmd_supported(cmd_q) && !i_inject_err,
                                         cmd_q, dev_q, lba_q, cnt_q};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_q   <= '0;
            w0ok_q  <= 1'b0;
            cmd_q   <= '0;
            dev_q   <= '0;
            lba_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= StIdle;
            dly_q   <= '0;
            oidx_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            w0ok_q  <= w0ok_d;
            cmd_q   <= cmd_d;
            dev_q   <= dev_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            dly_q   <= dly_d;
            oidx_q  <= oidx_d;
        end
    end

endmodule
